// File: rtl/riscv_fetch_pkg.sv
// riscv_fetch_pkg: shared widths, queue entry type and redirect checking
// for the instruction fetch unit.
package riscv_fetch_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;

  // One prefetch slot: the PC it was fetched from, the returned word,
  // and whether memory has answered yet.
  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic               filled;
  } fetch_entry_t;

  // A redirect is usable only if it lands inside the instruction memory
  // window and on a word boundary.
  function automatic logic redirect_ok(
    input logic [XLEN-1:0] target,
    input logic [XLEN-1:0] lo,
    input logic [XLEN-1:0] hi
  );
    return (target >= lo) && (target <= hi) && (target[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/ifu_prefetch_if.sv
// ifu_prefetch_if: bundles the fetch unit's memory, redirect and decode
// ports. The master side is the fetch unit itself.
interface ifu_prefetch_if;
  import riscv_fetch_pkg::*;

  logic               imem_req_valid;
  logic               imem_req_ready;
  logic [XLEN-1:0]    imem_req_addr;
  logic               imem_rsp_valid;
  logic [INSTR_W-1:0] imem_rsp_data;
  logic               redirect_valid;
  logic [XLEN-1:0]    redirect_target;
  logic               out_valid;
  logic               out_ready;
  logic [XLEN-1:0]    out_pc;
  logic [INSTR_W-1:0] out_instr;
  logic [XLEN-1:0]    out_next_pc;
  logic               halted;
  logic               redirect_fault;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_target,
    output out_valid, out_pc, out_instr, out_next_pc,
    input  out_ready,
    output halted, redirect_fault
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_target,
    input  out_valid, out_pc, out_instr, out_next_pc,
    output out_ready,
    input  halted, redirect_fault
  );

endinterface

// File: rtl/ifu_slot_queue.sv
// ifu_slot_queue: in-order prefetch queue. Slots are allocated when a
// request is issued, filled when its response returns, and popped by
// decode. Tracks total occupancy and how many slots still await memory.
module ifu_slot_queue
  import riscv_fetch_pkg::*;
#(
  parameter int QDEPTH = 4,
  localparam int PW    = $clog2(QDEPTH),
  localparam int CW    = $clog2(QDEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               alloc_en,
  input  logic [XLEN-1:0]    alloc_pc,
  input  logic               fill_en,
  input  logic [INSTR_W-1:0] fill_instr,
  input  logic               pop_en,
  output fetch_entry_t       head,
  output logic [CW-1:0]      occ,
  output logic [CW-1:0]      pend
);

  fetch_entry_t  entries [QDEPTH];
  logic [PW-1:0] alloc_ptr;
  logic [PW-1:0] fill_ptr;
  logic [PW-1:0] head_ptr;

  // Allocate, fill and pop touch distinct slots, so all three may happen in
  // one cycle; a flush empties everything and takes priority.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int i = 0; i < QDEPTH; i++) begin
        entries[i] <= '0;
      end
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      occ       <= '0;
      pend      <= '0;
    end else begin
      if (alloc_en) begin
        entries[alloc_ptr] <= '{pc: alloc_pc, instr: '0, filled: 1'b0};
        alloc_ptr          <= alloc_ptr + PW'(1);
      end
      if (fill_en) begin
        entries[fill_ptr].instr  <= fill_instr;
        entries[fill_ptr].filled <= 1'b1;
        fill_ptr                 <= fill_ptr + PW'(1);
      end
      if (pop_en) begin
        entries[head_ptr].filled <= 1'b0;
        head_ptr                 <= head_ptr + PW'(1);
      end
      occ  <= occ + CW'(alloc_en) - CW'(pop_en);
      pend <= pend + CW'(alloc_en) - CW'(fill_en);
    end
  end

  assign head = entries[head_ptr];

endmodule

// File: rtl/ifu_prefetch.sv
// ifu_prefetch: sequential instruction fetch with a decoupled prefetch
// queue, redirect flushing with in-flight response dropping, and a halt
// once fetch runs past the end of instruction memory.
module ifu_prefetch
  import riscv_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] IMEM_START = 32'h0000_0000,
  parameter logic [XLEN-1:0] IMEM_END   = 32'h0000_0064,
  parameter int              QDEPTH     = 4
) (
  input logic            clk,
  input logic            reset,
  ifu_prefetch_if.master bus
);

  localparam int            CW          = $clog2(QDEPTH + 1);
  localparam logic [CW:0]   DEPTH_LIMIT = (CW + 1)'(QDEPTH);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] next_pc;
  logic            halted_q;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   q_occ;
  logic [CW-1:0]   q_pend;
  logic [CW-1:0]   outstanding;
  logic [CW:0]     inflight;
  fetch_entry_t    head;
  logic            redirect_accept;
  logic            req_valid_int;
  logic            req_fire;
  logic            rsp_drop;
  logic            rsp_fill;
  logic            pop;
  logic            past_end;

  // Slots plus responses still owed to flushed requests bound how many
  // requests may be outstanding at once.
  assign inflight        = {1'b0, q_occ} + {1'b0, drop_cnt};
  assign outstanding     = drop_cnt + q_pend;
  assign redirect_accept = bus.redirect_valid
                           && redirect_ok(bus.redirect_target, IMEM_START, IMEM_END);
  assign req_valid_int   = !halted_q && (inflight < DEPTH_LIMIT) && !bus.redirect_valid;
  assign req_fire        = req_valid_int && bus.imem_req_ready;
  assign rsp_drop        = bus.imem_rsp_valid && (drop_cnt != '0);
  assign rsp_fill        = bus.imem_rsp_valid && (drop_cnt == '0) && (q_pend != '0);
  assign pop             = head.filled && bus.out_ready;
  assign next_pc         = fetch_pc + XLEN'(4);
  assign past_end        = (next_pc > IMEM_END) || (next_pc < fetch_pc);

  ifu_slot_queue #(
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect_accept),
    .alloc_en   (req_fire),
    .alloc_pc   (fetch_pc),
    .fill_en    (rsp_fill),
    .fill_instr (bus.imem_rsp_data),
    .pop_en     (pop),
    .head       (head),
    .occ        (q_occ),
    .pend       (q_pend)
  );

  // Fetch PC, halt flag and drop counter; an accepted redirect turns every
  // unanswered request into one to be discarded, less any answered now.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= IMEM_START;
      halted_q <= 1'b0;
      drop_cnt <= '0;
    end else if (redirect_accept) begin
      fetch_pc <= bus.redirect_target;
      halted_q <= 1'b0;
      drop_cnt <= outstanding - CW'(bus.imem_rsp_valid && (outstanding != '0));
    end else begin
      if (req_fire) begin
        fetch_pc <= next_pc;
        if (past_end) begin
          halted_q <= 1'b1;
        end
      end
      if (rsp_drop) begin
        drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

  // Outputs are forced quiet while reset is held so nothing leaks from the
  // state being cleared.
  assign bus.imem_req_valid = !reset && req_valid_int;
  assign bus.imem_req_addr  = reset ? '0 : fetch_pc;
  assign bus.out_valid      = !reset && head.filled;
  assign bus.out_pc         = reset ? '0 : head.pc;
  assign bus.out_instr      = reset ? '0 : head.instr;
  assign bus.out_next_pc    = reset ? '0 : head.pc + XLEN'(4);
  assign bus.halted         = !reset && halted_q;
  assign bus.redirect_fault = !reset && bus.redirect_valid && !redirect_accept;

endmodule
